uart_tx_drain: RTL and testbench
================================

// Module: uart_tx_drain
// PURPOSE
//  Downstream consumer of the FIFO block: pops one word at a time whenever the FIFO is
//  non-empty and serialises it onto a UART TX line (8N1 by default, optional parity / 2 stop).
//  Sits between the FIFO's pop/readData/empty interface and the board TX pin.
//  Never pops an empty FIFO; tolerates the FIFO's one-cycle registered read latency.
// PARAMETERS
//  DATA_SIZE     8            word width; must match FIFO DATA_SIZE
//  CLK_FREQ_HZ   100_000_000  clk frequency
//  BAUD_RATE     115200       line rate; CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD_RATE/2) / BAUD_RATE, must be >= 2
//  PARITY_EN     0            1 = append a parity bit after the data bits
//  PARITY_ODD    0            0 = even parity, 1 = odd (ignored if PARITY_EN = 0)
//  STOP_BITS     1            1 or 2
// PORTS
//  clk         in   1          clock, all logic on posedge
//  rst         in   1          reset, asynchronous, active-high
//  enable      in   1          1 = allowed to start new frames
//  fifo_empty  in   1          FIFO empty flag
//  fifo_pop    out  1          one-cycle pop strobe to FIFO
//  fifo_data   in   DATA_SIZE  FIFO readData (valid the cycle after fifo_pop)
//  tx          out  1          serial line, idle high, registered
//  busy        out  1          1 from pop until end of last stop bit
//  frame_done  out  1          one-cycle pulse on the last cycle of the last stop bit
// BEHAVIOUR
//  Reset (async): tx=1, fifo_pop=0, busy=0, frame_done=0, state=IDLE, counters=0, shift reg=0.
//  FSM: IDLE -> POP -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - IDLE: tx=1, busy=0. If enable && !fifo_empty: fifo_pop=1 for exactly this cycle, go POP.
//  - POP: fifo_pop=0, busy=1; FIFO updates readData on this edge. Go LOAD.
//  - LOAD: capture fifo_data into shift reg, compute parity (^data, inverted if PARITY_ODD), go START.
//  - START: tx=0 for CLKS_PER_BIT cycles.
//  - DATA: DATA_SIZE bits LSB first, each CLKS_PER_BIT cycles; bit counter 0..DATA_SIZE-1.
//  - PARITY (only if PARITY_EN): tx=parity bit for CLKS_PER_BIT cycles.
//  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles; frame_done=1 on final cycle; go IDLE.
//  - Pop-to-first-start-bit latency: tx falls on the clock edge ending LOAD (3 cycles after pop asserted).
//  - Back-to-back: minimum inter-frame gap = 3 cycles of tx high (IDLE, POP, LOAD) beyond stop bits.
//  - Baud counter: width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1, wraps to 0 on bit advance;
//    restarted at 0 on entry to START. No fractional-baud correction.
//  - fifo_pop only ever asserted in IDLE with fifo_empty=0; never two pops in one frame.
//  - enable deasserted mid-frame: current frame completes normally; no further pops.
//  - fifo_empty rising after pop: ignored, data already committed.
//  - Reset mid-frame: tx returns high immediately; in-flight word lost, FIFO not re-read.
//  - tx, fifo_pop, frame_done driven from registers only (no combinational outputs).
// STRUCTURE
//  Shared include uart_defs.vh: state encodings (IDLE..STOP, 3-bit localparams),
//  CLKS_PER_BIT computation macro, bit-counter width $clog2(DATA_SIZE).
//  One sub-module: uart_baud_tick (counter + tick output, restart input), instantiated once.
//  FSM, shift register and parity logic stay in uart_tx_drain.
// TESTING  (CLK_FREQ_HZ=40, BAUD_RATE=10 -> CLKS_PER_BIT=4; FIFO model with 1-cycle readData latency)
//  1 Reset: hold rst 3 cycles -> tx=1, busy=0, fifo_pop=0, frame_done=0; release with FIFO empty -> no pop for 100 cycles.
//  2 Single byte 0xA5 -> one pop; tx per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1; frame_done one pulse; 40 cycles start-to-stop-end.
//  3 Three bytes 0x00,0xFF,0x3C queued -> exactly 3 pops, frames in order, 3-cycle high gap after each stop, FIFO empty at end.
//  4 PARITY_EN=1: 0x07 even -> parity bit 1; PARITY_ODD=1 -> 0; STOP_BITS=2 -> stop high 8 cycles.
//  5 enable dropped mid-DATA with 2 bytes queued -> current frame completes, no further pop until enable=1.
//  6 rst asserted during DATA bit 3 -> tx=1 same cycle (async), busy=0; after release with data queued -> fresh frame from next word.

Source files
------------

// File: rtl/uart_tx_drain_pkg.sv
// Shared types and helpers for the FIFO-draining UART transmitter.
package uart_tx_drain_pkg;

  // Frame sequencer states; the 3-bit encoding keeps the FSM register small
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_t;

  // Clocks per serial bit, rounded to the nearest integer divisor
  function automatic int clks_per_bit(input int clk_freq_hz, input int baud_rate);
    return (clk_freq_hz + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last and
// second-to-last cycle of each bit. Held at zero while restart is high.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick,
  output logic pre_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt;

  // Free-running bit-period counter, wraps on the last cycle of a bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick     = (cnt == CNT_LAST);
  assign pre_tick = (cnt == CNT_PRE);

endmodule

// File: rtl/uart_tx_drain.sv
// Pops words from a FIFO with one-cycle registered read latency and
// serialises each onto a UART TX line (start, data LSB first, optional
// parity, 1 or 2 stop bits). All outputs come straight from registers.
module uart_tx_drain
  import uart_tx_drain_pkg::*;
#(
  parameter int DATA_SIZE   = 8,
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 fifo_empty,
  output logic                 fifo_pop,
  input  logic [DATA_SIZE-1:0] fifo_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int BIT_W        = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_SIZE - 1);
  // Index of the final stop bit (0 for one stop bit, 1 for two)
  localparam logic STOP_LAST = (STOP_BITS == 2);

  state_t               state;
  logic [DATA_SIZE-1:0] shreg;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic                 parity_bit;
  logic                 baud_restart;
  logic                 baud_tick;
  logic                 baud_pre_tick;

  // Even parity is the XOR of the data; odd parity is its complement
  function automatic logic calc_parity(input logic [DATA_SIZE-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  // Keep the bit timer parked at zero until the start bit begins, so the
  // start bit always gets a full bit period
  assign baud_restart = (state == ST_IDLE) || (state == ST_POP) || (state == ST_LOAD);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (baud_restart),
    .tick    (baud_tick),
    .pre_tick(baud_pre_tick)
  );

  // Frame sequencer: pop, wait out FIFO read latency, then shift the frame out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      tx         <= 1'b1;
      fifo_pop   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      parity_bit <= 1'b0;
    end else begin
      fifo_pop   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          // enable is only sampled here, so dropping it mid-frame lets the
          // current frame finish and simply blocks the next pop
          if (enable && !fifo_empty) begin
            fifo_pop <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_POP;
          end
        end
        ST_POP: begin
          // FIFO presents the popped word on the edge that ends this state
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          shreg      <= fifo_data;
          parity_bit <= calc_parity(fifo_data);
          bit_cnt    <= '0;
          stop_cnt   <= 1'b0;
          tx         <= 1'b0;
          state      <= ST_START;
        end
        ST_START: begin
          if (baud_tick) begin
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            if (bit_cnt == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                tx    <= parity_bit;
                state <= ST_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= ST_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (baud_tick) begin
            tx    <= 1'b1;
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Set one cycle early so the registered pulse lands on the final cycle
          if (baud_pre_tick && (stop_cnt == STOP_LAST)) begin
            frame_done <= 1'b1;
          end
          if (baud_tick) begin
            if (stop_cnt == STOP_LAST) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain at 4 clocks per bit: an 8N1 instance driven from a
// scoreboarded FIFO model, plus even/2-stop and odd/1-stop parity instances.
module tb_uart_tx_drain;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  logic en_par = 1'b1;

  logic pop0, pop1, pop2;
  logic empty0, empty1, empty2;
  logic tx0, tx1, tx2;
  logic busy0, busy1, busy2;
  logic fd0, fd1, fd2;
  logic [7:0] rdata0 = '0;
  logic [7:0] rdata1 = '0;
  logic [7:0] rdata2 = '0;

  logic [7:0] mem0 [0:63];
  logic [7:0] mem1 [0:7];
  logic [7:0] mem2 [0:7];
  int wp0 = 0, wp1 = 0, wp2 = 0;
  int rp0 = 0, rp1 = 0, rp2 = 0;
  int popcnt0 = 0, popcnt1 = 0, popcnt2 = 0;
  int pop_empty_err = 0;

  int checks = 0;
  int errors = 0;
  int frames0 = 0;
  int last_gap = 0;
  logic [9:0] exp0 [$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // bit i = i-th bit on the line: start, d0..d7, stop
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  assign empty0 = (wp0 == rp0);
  assign empty1 = (wp1 == rp1);
  assign empty2 = (wp2 == rp2);

  uart_tx_drain #(.DATA_SIZE(8), .CLK_FREQ_HZ(40), .BAUD_RATE(10),
                  .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(empty0), .fifo_pop(pop0),
    .fifo_data(rdata0), .tx(tx0), .busy(busy0), .frame_done(fd0));

  uart_tx_drain #(.DATA_SIZE(8), .CLK_FREQ_HZ(40), .BAUD_RATE(10),
                  .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .enable(en_par), .fifo_empty(empty1), .fifo_pop(pop1),
    .fifo_data(rdata1), .tx(tx1), .busy(busy1), .frame_done(fd1));

  uart_tx_drain #(.DATA_SIZE(8), .CLK_FREQ_HZ(40), .BAUD_RATE(10),
                  .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .enable(en_par), .fifo_empty(empty2), .fifo_pop(pop2),
    .fifo_data(rdata2), .tx(tx2), .busy(busy2), .frame_done(fd2));

  // FIFO models: readData updates on the edge that samples pop
  always @(posedge clk) begin
    if (pop0) begin
      popcnt0 <= popcnt0 + 1;
      if (wp0 == rp0) pop_empty_err <= pop_empty_err + 1;
      else begin rdata0 <= mem0[rp0]; rp0 <= rp0 + 1; end
    end
    if (pop1) begin
      popcnt1 <= popcnt1 + 1;
      if (wp1 == rp1) pop_empty_err <= pop_empty_err + 1;
      else begin rdata1 <= mem1[rp1]; rp1 <= rp1 + 1; end
    end
    if (pop2) begin
      popcnt2 <= popcnt2 + 1;
      if (wp2 == rp2) pop_empty_err <= pop_empty_err + 1;
      else begin rdata2 <= mem2[rp2]; rp2 <= rp2 + 1; end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push0(input int idx);
    mem0[wp0] = vecs[idx].data;
    wp0 = wp0 + 1;
    exp0.push_back(vecs[idx].frame);
  endtask

  // Follows every frame on tx0 and checks it cycle by cycle against the scoreboard
  task automatic monitor0();
    bit act = 0;
    int cyc = 0;
    int gap = 100;
    logic [9:0] fr = '1;
    forever begin
      @(negedge clk);
      if (rst) begin
        act = 0;
        gap = 100;
      end else begin
        if (!act) begin
          if (tx0 == 1'b0) begin
            last_gap = gap;
            chk("frame_expected", {31'd0, exp0.size() != 0}, 32'd1);
            fr = (exp0.size() != 0) ? exp0.pop_front() : 10'h3FF;
            act = 1;
            cyc = 0;
          end else begin
            gap++;
            chk("frame_done_idle", {31'd0, fd0}, 32'd0);
          end
        end
        if (act) begin
          chk($sformatf("tx0_bit%0d", cyc / 4), {31'd0, tx0}, {31'd0, fr[cyc / 4]});
          chk("busy0_in_frame", {31'd0, busy0}, 32'd1);
          chk("frame_done0", {31'd0, fd0}, {31'd0, cyc == 39});
          cyc++;
          if (cyc == 40) begin
            act = 0;
            gap = 0;
            frames0++;
          end
        end
      end
    end
  endtask

  task automatic wait_frames(input int target, input int maxcyc, input string name);
    for (int i = 0; i < maxcyc && frames0 < target; i++) @(negedge clk);
    chk(name, frames0, target);
  endtask

  task automatic wait_tx0_low(input string name);
    for (int i = 0; i < 60 && tx0 !== 1'b0; i++) @(negedge clk);
    chk(name, {31'd0, tx0}, 32'd0);
  endtask

  function automatic logic get_tx(input int s);
    return (s == 1) ? tx1 : tx2;
  endfunction

  function automatic logic get_fd(input int s);
    return (s == 1) ? fd1 : fd2;
  endfunction

  // Hand-checks one frame from a parity instance, bit value at mid-bit
  task automatic check_frame_sel(input int s, input logic [11:0] fr, input int nbits, input string nm);
    for (int i = 0; i < 40 && get_tx(s) !== 1'b0; i++) @(negedge clk);
    chk({nm, "_start"}, {31'd0, get_tx(s)}, 32'd0);
    for (int c = 0; c < nbits * 4; c++) begin
      if (c % 4 == 2) chk($sformatf("%s_bit%0d", nm, c / 4), {31'd0, get_tx(s)}, {31'd0, fr[c / 4]});
      chk({nm, "_frame_done"}, {31'd0, get_fd(s)}, {31'd0, c == nbits * 4 - 1});
      @(negedge clk);
    end
    chk({nm, "_idle_high"}, {31'd0, get_tx(s)}, 32'd1);
    chk({nm, "_done_low"}, {31'd0, get_fd(s)}, 32'd0);
  endtask

  initial begin
    int f, p;
    vecs[0] = '{data: 8'hA5, frame: 10'b1101001010};
    vecs[1] = '{data: 8'h00, frame: 10'b1000000000};
    vecs[2] = '{data: 8'hFF, frame: 10'b1111111110};
    vecs[3] = '{data: 8'h3C, frame: 10'b1001111000};
    vecs[4] = '{data: 8'h55, frame: 10'b1010101010};
    vecs[5] = '{data: 8'h81, frame: 10'b1100000010};

    fork
      monitor0();
    join_none

    // 1: reset values, then no pops while the FIFO stays empty
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx0", {31'd0, tx0}, 32'd1);
      chk("rst_busy0", {31'd0, busy0}, 32'd0);
      chk("rst_pop0", {31'd0, pop0}, 32'd0);
      chk("rst_fd0", {31'd0, fd0}, 32'd0);
    end
    chk("rst_tx1", {31'd0, tx1}, 32'd1);
    chk("rst_tx2", {31'd0, tx2}, 32'd1);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("no_pop_when_empty", popcnt0, 0);
    chk("idle_tx0", {31'd0, tx0}, 32'd1);

    // 2: single word, pop width and pop-to-start latency
    f = frames0; p = popcnt0;
    push0(0);
    for (int i = 0; i < 20 && pop0 !== 1'b1; i++) @(negedge clk);
    chk("pop_seen", {31'd0, pop0}, 32'd1);
    chk("busy_at_pop", {31'd0, busy0}, 32'd1);
    @(negedge clk);
    chk("pop_one_cycle", {31'd0, pop0}, 32'd0);
    chk("tx_high_in_load", {31'd0, tx0}, 32'd1);
    @(negedge clk);
    chk("tx_fall_after_load", {31'd0, tx0}, 32'd0);
    wait_frames(f + 1, 80, "t2_frame");
    chk("t2_pops", popcnt0 - p, 1);
    chk("t2_fifo_empty", {31'd0, empty0}, 32'd1);

    // 3: three words queued back-to-back
    repeat (5) @(negedge clk);
    f = frames0; p = popcnt0;
    for (int i = 1; i <= 3; i++) push0(i);
    wait_frames(f + 1, 100, "t3_frame1");
    wait_frames(f + 2, 100, "t3_frame2");
    chk("t3_gap1", last_gap, 3);
    wait_frames(f + 3, 100, "t3_frame3");
    chk("t3_gap2", last_gap, 3);
    chk("t3_pops", popcnt0 - p, 3);
    chk("t3_fifo_empty", {31'd0, empty0}, 32'd1);

    // 4: parity and stop-bit variants on 0x07
    mem1[wp1] = 8'h07; wp1 = wp1 + 1;
    check_frame_sel(1, 12'b111000001110, 12, "even2stop");
    mem2[wp2] = 8'h07; wp2 = wp2 + 1;
    check_frame_sel(2, 12'b010000001110, 11, "odd1stop");
    chk("t4_pops1", popcnt1, 1);
    chk("t4_pops2", popcnt2, 1);

    // 5: enable dropped mid-DATA with two words queued
    @(negedge clk);
    f = frames0; p = popcnt0;
    push0(1); push0(3);
    wait_tx0_low("t5_start");
    repeat (12) @(negedge clk);
    enable = 1'b0;
    wait_frames(f + 1, 100, "t5_frame1");
    repeat (30) @(negedge clk);
    chk("t5_no_pop_disabled", popcnt0 - p, 1);
    chk("t5_word_left", wp0 - rp0, 1);
    chk("t5_idle_tx", {31'd0, tx0}, 32'd1);
    enable = 1'b1;
    wait_frames(f + 2, 100, "t5_frame2");
    chk("t5_pops", popcnt0 - p, 2);

    // 6: async reset during data bit 3 drops the word in flight
    repeat (5) @(negedge clk);
    f = frames0; p = popcnt0;
    push0(4); push0(5);
    wait_tx0_low("t6_start");
    repeat (17) @(negedge clk);
    chk("t6_tx_bit3_low", {31'd0, tx0}, 32'd0);
    chk("t6_busy_before", {31'd0, busy0}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_tx", {31'd0, tx0}, 32'd1);
    chk("t6_async_busy", {31'd0, busy0}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_frames(f + 1, 120, "t6_fresh_frame");
    chk("t6_pops", popcnt0 - p, 2);
    chk("t6_fifo_empty", {31'd0, empty0}, 32'd1);

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", exp0.size(), 0);
    chk("pop_while_empty", pop_empty_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
